// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: state encoding, no-hit marker and length normalisation shared by seq_scan_ctrl.
package seq_scan_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;
  localparam logic [31:0] NO_HIT = '1;
  function automatic int norm_len(input int len, input int width);
    return (len == 0 || len > width) ? width : len;
  endfunction
endpackage

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: serialises a parallel word MSB-first into a sequence detector,
// counts its flag pulses and records the position of the first hit.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int   WIDTH    = 32,
  parameter int   CNT_W    = 6,
  parameter int   FLAG_LAT = 1,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] start_data,
  input  logic [CNT_W-1:0] start_len,
  output logic             det_din,
  input  logic             det_flag,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] first_pos
);
  // c runs through L shift cycles plus FLAG_LAT drain cycles
  localparam int CW = $clog2(WIDTH + FLAG_LAT + 1);
  state_t           r_state, w_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_len, w_len, r_hit_cnt, r_first;
  logic [CW-1:0]    r_c, w_shift_end, w_drain_end;
  logic             r_seen, r_din, w_acc, w_hit;

  assign w_len       = CNT_W'(norm_len(int'(start_len), WIDTH));
  assign w_shift_end = CW'(r_len) - CW'(1);
  assign w_drain_end = CW'(r_len) + CW'(FLAG_LAT) - CW'(1);
  assign w_acc       = (r_state == IDLE) && start_valid;
  // flags seen before FLAG_LAT cycles belong to the previous word's traffic
  assign w_hit       = (r_state == SHIFT || r_state == DRAIN) && det_flag && (r_c >= CW'(FLAG_LAT));

  always_comb begin
    w_nxt       = r_state;
    start_ready = r_state == IDLE;
    busy        = r_state != IDLE;
    done        = r_state == DONE;
    unique case (r_state)
      IDLE:  w_nxt = start_valid ? SHIFT : IDLE;
      SHIFT: w_nxt = (r_c != w_shift_end) ? SHIFT : (FLAG_LAT == 0) ? DONE : DRAIN;
      DRAIN: w_nxt = (r_c == w_drain_end) ? DONE : DRAIN;
      DONE:  w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sr      <= '0;
      r_len     <= '0;
      r_c       <= '0;
      r_din     <= IDLE_BIT;
      r_hit_cnt <= '0;
      r_first   <= NO_HIT[CNT_W-1:0];
      r_seen    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_c     <= r_c + CW'(1);
      r_din   <= IDLE_BIT;
      r_sr    <= r_sr << 1;
      if (w_acc) begin
        r_sr      <= start_data << 1;
        r_din     <= start_data[WIDTH-1];
        r_len     <= w_len;
        r_c       <= '0;
        r_hit_cnt <= '0;
        r_first   <= NO_HIT[CNT_W-1:0];
        r_seen    <= 1'b0;
      end else if (r_state == SHIFT && r_c != w_shift_end) begin
        r_din <= r_sr[WIDTH-1];
      end
      if (w_hit) begin
        r_hit_cnt <= r_hit_cnt + {{(CNT_W-1){1'b0}}, ~&r_hit_cnt};
        r_seen    <= 1'b1;
        if (!r_seen) r_first <= CNT_W'(r_c - CW'(FLAG_LAT));
      end
    end
  end

  assign det_din   = r_din;
  assign hit_cnt   = r_hit_cnt;
  assign first_pos = r_first;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: drives seq_scan_ctrl into a Moore "101" detector and checks
// every cycle against a word-level model plus hand-computed results.
module tb_seq_scan_ctrl;
  localparam int FL = 1;
  logic        clk = 1'b0, rst_n = 1'b0, start_valid = 1'b0;
  logic [31:0] start_data = '0;
  logic [5:0]  start_len = '0;
  logic        start_ready, det_din, det_flag, busy, done;
  logic [5:0]  hit_cnt, first_pos;
  logic [2:0]  hist;
  int          checks = 0, failures = 0, n = 0;
  int          m_acc = 0, m_L = 0, m_cnt = 0, m_first = 63, m_res_cnt = 0, m_res_first = 63;
  bit          m_act = 1'b0;
  logic [31:0] m_d = '0;

  always #5 clk = ~clk;

  seq_scan_ctrl #(.WIDTH(32), .CNT_W(6), .FLAG_LAT(FL), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .start_data(start_data), .start_len(start_len), .det_din(det_din), .det_flag(det_flag),
    .busy(busy), .done(done), .hit_cnt(hit_cnt), .first_pos(first_pos)
  );

  // Moore overlapping "101" detector, flag one clock after the completing bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= '0;
    else hist <= {hist[1:0], det_din};
  end
  assign det_flag = hist == 3'b101;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // word-level expectation: every index i where bits i-2..i read 1,0,1 (idle zeros precede a word)
  function automatic void model(input logic [31:0] d, input int len, output int l, output int cnt, output int first);
    l = (len == 0 || len > 32) ? 32 : len;
    cnt = 0;
    first = 63;
    for (int i = 2; i < l; i++)
      if (d[33-i] && !d[32-i] && d[31-i]) begin
        cnt++;
        if (first == 63) first = i;
      end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0;
      m_res_cnt = 0;
      m_res_first = 63;
    end else begin
      n++;
      if ((!m_act || (n - 1 - m_acc) > m_L + FL) && start_valid) begin
        m_act = 1'b1;
        m_acc = n;
        m_d = start_data;
        model(start_data, int'(start_len), m_L, m_cnt, m_first);
      end else if (m_act && n - m_acc == m_L + FL) begin
        m_res_cnt = m_cnt;
        m_res_first = m_first;
      end
    end
  end

  always @(negedge clk) begin
    int  e;
    bit  eb;
    e  = n - m_acc;
    eb = m_act && e <= m_L + FL;
    chk("ready", 32'(start_ready), 32'(!eb));
    chk("busy", 32'(busy), 32'(eb));
    chk("done", 32'(done), 32'(eb && e == m_L + FL));
    chk("din", 32'(det_din), 32'((eb && e < m_L) ? m_d[31-e] : 1'b0));
    if (!eb || e == m_L + FL) begin
      chk("hit_cnt", 32'(hit_cnt), 32'(m_res_cnt));
      chk("first_pos", 32'(first_pos), 32'(m_res_first));
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 200 && !start_ready; k++) @(negedge clk);
    chk("ready_timeout", 32'(start_ready), 1);
  endtask

  task automatic send(input logic [31:0] d, input logic [5:0] l, output int acc);
    start_valid = 1'b1;
    start_data = d;
    start_len = l;
    wait_ready();
    @(negedge clk);
    acc = n;
    start_valid = 1'b0;
  endtask

  task automatic wait_done(output int dn);
    for (int k = 0; k < 100 && !done; k++) @(negedge clk);
    chk("done_timeout", 32'(done), 1);
    dn = n;
  endtask

  task automatic word_chk(input string nm, input int lat, input int el, input int ec, input int ef);
    chk({nm, "_lat"}, 32'(lat), 32'(el));
    chk({nm, "_cnt"}, 32'(hit_cnt), 32'(ec));
    chk({nm, "_first"}, 32'(first_pos), 32'(ef));
  endtask

  initial begin
    int acc, acc2, dn, ml, mc, mf;
    model(32'hC646A4A2, 0, ml, mc, mf);
    chk("model_len", 32'(ml), 32);
    chk("model_cnt", 32'(mc), 3);
    chk("model_first", 32'(mf), 16);
    model(32'hA0000000, 8, ml, mc, mf);
    chk("model_short", 32'(mc * 100 + mf), 102);
    repeat (3) @(negedge clk);
    chk("rst_first", 32'(first_pos), 63);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(32'hC646A4A2, 6'd0, acc);
    wait_done(dn);
    word_chk("full", dn - acc, 33, 3, 16);
    send(32'hA0000000, 6'd8, acc);
    wait_done(dn);
    word_chk("short", dn - acc, 9, 1, 2);
    send(32'hFFFFFFFF, 6'd0, acc);
    wait_done(dn);
    word_chk("nohit", dn - acc, 33, 0, 63);
    send(32'hC646A4A2, 6'd40, acc);
    wait_done(dn);
    word_chk("clamp", dn - acc, 33, 3, 16);
    start_valid = 1'b1;
    start_data = 32'hA0000000;
    start_len = 6'd8;
    wait_ready();
    @(negedge clk);
    acc = n;
    start_data = 32'hC646A4A2;
    start_len = 6'd0;
    wait_done(dn);
    word_chk("b2b1", dn - acc, 9, 1, 2);
    wait_ready();
    @(negedge clk);
    acc2 = n;
    start_valid = 1'b0;
    chk("b2b_gap", 32'(acc2 - dn), 2);
    chk("b2b_period", 32'(acc2 - acc), 11);
    wait_done(dn);
    word_chk("b2b2", dn - acc2, 33, 3, 16);
    send(32'hC646A4A2, 6'd0, acc);
    for (int k = 0; k < 50 && n - acc < 10; k++) @(negedge clk);
    chk("rst_at_bit10", 32'(n - acc), 10);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(start_ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_din", 32'(det_din), 0);
    chk("rst_cnt", 32'(hit_cnt), 0);
    chk("rst_first_pos", 32'(first_pos), 63);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    send(32'hC646A4A2, 6'd0, acc);
    wait_done(dn);
    word_chk("post_rst", dn - acc, 33, 3, 16);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
